inport_buffered: RTL

Parametrised, multi-packet router input port for the hexa mesh NoC. It detects packet starts on the toggling differential strobe pair and stores up to DEPTH_PKTS fixed-length packets in an internal flit buffer. It computes an XY route from each packet's header, raises one request toward the crossbar arbiter, and streams the packet out on acknowledge. It returns a credit pulse upstream each time a packet slot is freed.

---
 rtl/inport_buffered.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/inport_buffered.sv
// Router input port: strobe-framed packet capture into a multi-slot flit buffer, XY route request, cut-through send.
// Latency: request registered at the header edge; flit i leaves i+1 cycles after the grant edge.
// Backpressure: credit pulse per freed slot; a header arriving into a full buffer is dropped and ovf sticks.
module inport_buffered #(
    parameter int FLIT_W     = 32,
    parameter int PKT_FLITS  = 4,
    parameter int DEPTH_PKTS = 2,
    parameter int ADDR_W     = 4,
    parameter int X_LOCAL    = 2,
    parameter int Y_LOCAL    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              diff_pair_p,
    input  logic              diff_pair_n,
    input  logic [FLIT_W-1:0] input_channel,
    input  logic              arb_ack,
    output logic [FLIT_W-1:0] channel_data,
    output logic              data_valid,
    output logic              crt_out,
    output logic [3:0]        port_rqs,
    output logic              pe_rqs,
    output logic              ovf
);
    localparam int SW = (DEPTH_PKTS > 1) ? $clog2(DEPTH_PKTS) : 1;
    localparam int FW = $clog2(PKT_FLITS);
    localparam int CW = $clog2(DEPTH_PKTS + 1);
    localparam logic [SW-1:0]     SLOT_LAST = SW'(DEPTH_PKTS - 1);
    localparam logic [FW-1:0]     FLIT_LAST = FW'(PKT_FLITS - 1);
    localparam logic [CW-1:0]     CNT_FULL  = CW'(DEPTH_PKTS);
    localparam logic [ADDR_W-1:0] XL        = ADDR_W'(X_LOCAL);
    localparam logic [ADDR_W-1:0] YL        = ADDR_W'(Y_LOCAL);

    typedef enum logic       {RX_IDLE, RX_BODY}          rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_SEND}  tx_state_t;

    logic [FLIT_W-1:0] mem       [DEPTH_PKTS][PKT_FLITS];
    logic [4:0]        route_mem [DEPTH_PKTS];

    logic              p_prev;
    rx_state_t         rx_state, rx_nxt;
    tx_state_t         tx_state, tx_nxt;
    logic [FW-1:0]     rx_flit, rd_flit;
    logic [SW-1:0]     rx_slot, tail, head, head_nxt;
    logic              rx_drop;
    logic [CW-1:0]     count, count_nxt;
    logic [4:0]        req_route, route_sel, hdr_route;
    logic              start, accept, free, use_new;

    // Route one-hot: {pe, y-, y+, x-, x+}; X is resolved before Y.
    function automatic logic [4:0] xy_route(input logic [2*ADDR_W-1:0] dst);
        logic [ADDR_W-1:0] dx;
        logic [ADDR_W-1:0] dy;
        dx = dst[2*ADDR_W-1 -: ADDR_W];
        dy = dst[ADDR_W-1:0];
        if (dx > XL)      return 5'b00001;
        else if (dx < XL) return 5'b00010;
        else if (dy > YL) return 5'b00100;
        else if (dy < YL) return 5'b01000;
        else              return 5'b10000;
    endfunction

    function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
        return (s == SLOT_LAST) ? '0 : s + 1'b1;
    endfunction

    assign start     = (rx_state == RX_IDLE) && (diff_pair_p != p_prev) && (diff_pair_n == ~diff_pair_p);
    assign free      = (tx_state == TX_SEND) && (rd_flit == FLIT_LAST);
    assign accept    = start && ((count != CNT_FULL) || free);
    assign hdr_route = xy_route(input_channel[FLIT_W-1 -: 2*ADDR_W]);

    // The packet at the head after this edge is the incoming header only when nothing else remains buffered.
    always_comb begin
        count_nxt = count;
        if (accept && !free)
            count_nxt = count + 1'b1;
        else if (!accept && free)
            count_nxt = count - 1'b1;
        head_nxt  = free ? slot_inc(head) : head;
        use_new   = accept && (count == CW'(free));
        route_sel = use_new ? hdr_route : route_mem[head_nxt];
    end

    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            RX_IDLE: if (start) rx_nxt = RX_BODY;
            RX_BODY: if (rx_flit == FLIT_LAST) rx_nxt = RX_IDLE;
            default: rx_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_nxt = tx_state;
        case (tx_state)
            TX_IDLE: if (count_nxt != '0) tx_nxt = TX_REQ;
            TX_REQ:  if (arb_ack) tx_nxt = TX_SEND;
            TX_SEND: if (free) tx_nxt = (count_nxt != '0) ? TX_REQ : TX_IDLE;
            default: tx_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        channel_data = '0;
        data_valid   = 1'b0;
        crt_out      = 1'b0;
        if (tx_state == TX_SEND) begin
            channel_data = mem[head][rd_flit];
            data_valid   = 1'b1;
            crt_out      = free;
        end
        port_rqs = req_route[3:0];
        pe_rqs   = req_route[4];
    end

    always_ff @(posedge clk) begin
        // Tracks the line even in reset so leaving reset never looks like a toggle.
        p_prev <= diff_pair_p;
        if (rst) begin
            rx_state  <= RX_IDLE;
            tx_state  <= TX_IDLE;
            rx_flit   <= '0;
            rx_slot   <= '0;
            rx_drop   <= 1'b0;
            tail      <= '0;
            head      <= '0;
            count     <= '0;
            rd_flit   <= '0;
            req_route <= '0;
            ovf       <= 1'b0;
        end else begin
            rx_state  <= rx_nxt;
            tx_state  <= tx_nxt;
            count     <= count_nxt;
            head      <= head_nxt;
            req_route <= (tx_nxt == TX_REQ) ? route_sel : '0;
            if (start) begin
                rx_flit <= FW'(1);
                rx_slot <= tail;
                rx_drop <= !accept;
            end else if (rx_state == RX_BODY) begin
                rx_flit <= (rx_flit == FLIT_LAST) ? '0 : rx_flit + 1'b1;
            end
            if (accept)
                tail <= slot_inc(tail);
            if (start && !accept)
                ovf <= 1'b1;
            if (tx_state == TX_SEND)
                rd_flit <= free ? '0 : rd_flit + 1'b1;
            else
                rd_flit <= '0;
        end
    end

    // Dropped packets still walk RX_BODY so their body flits are skipped, not captured.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[tail][0]    <= input_channel;
            route_mem[tail] <= hdr_route;
        end
        if (!rst && (rx_state == RX_BODY) && !rx_drop)
            mem[rx_slot][rx_flit] <= input_channel;
    end
endmodule
